// File: rtl/trivium_stream_ctrl_pkg.sv
// Shared types and defaults for the Trivium keystream sequencer.
package trivium_pkg;

  localparam int TRIVIUM_KEY_W  = 80;
  localparam int TRIVIUM_IV_W   = 80;
  localparam int TRIVIUM_WARMUP = 1152;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WARM,
    ST_FILL,
    ST_RUN
  } trivium_ctrl_state_t;

endpackage

// File: rtl/trivium_stream_ctrl_if.sv
// Plaintext-in / ciphertext-out byte streams, valid/ready on both sides.
interface trivium_stream_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  // Datapath side: offers plaintext, consumes ciphertext.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/trivium_stream_ctrl.sv
// Trivium sequencer: keys the sibling core, runs warm-up, packs keystream
// bits LSB-first into bytes and XORs each byte with one plaintext byte.
module trivium_stream_ctrl
  import trivium_pkg::*;
#(
  parameter int WARMUP = TRIVIUM_WARMUP,
  parameter int KEY_W  = TRIVIUM_KEY_W,
  parameter int IV_W   = TRIVIUM_IV_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KEY_W-1:0]     key,
  input  logic [IV_W-1:0]      iv,
  trivium_stream_ctrl_if.slave bus,
  output logic                 keyed,
  output logic                 core_load,
  output logic [KEY_W-1:0]     core_key,
  output logic [IV_W-1:0]      core_iv,
  output logic                 core_en,
  input  logic                 core_ks
);

  localparam int WCW = $clog2(WARMUP + 1);

  trivium_ctrl_state_t state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       ks_q, ks_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IV_W-1:0]  iv_q, iv_d;
  logic             ov_q, ov_d;
  logic [7:0]       od_q, od_d;
  logic             in_ready_c;
  logic             in_fire;

  // State and datapath registers; reset forces a full re-key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      ks_q    <= '0;
      key_q   <= '0;
      iv_q    <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      ks_q    <= ks_d;
      key_q   <= key_d;
      iv_q    <= iv_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  // Next-state, byte packing and stream handshakes; start overrides all.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    ks_d    = ks_q;
    key_d   = key_q;
    iv_d    = iv_q;
    ov_d    = ov_q;
    od_d    = od_q;

    // Accept only while holding a fresh keystream byte and the output slot
    // is free or draining this cycle; a re-key request blocks acceptance.
    in_ready_c = (state_q == ST_RUN) && !start && (!ov_q || bus.out_ready);
    in_fire    = in_ready_c && bus.in_valid;

    if (ov_q && bus.out_ready) ov_d = 1'b0;

    case (state_q)
      ST_LOAD: begin
        wcnt_d  = '0;
        state_d = ST_WARM;
      end
      ST_WARM: begin
        wcnt_d = wcnt_q + WCW'(1);
        if (wcnt_q == WCW'(WARMUP - 1)) begin
          bcnt_d  = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        ks_d[bcnt_q] = core_ks;
        bcnt_d       = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (in_fire) begin
          od_d    = bus.in_data ^ ks_q;
          ov_d    = 1'b1;
          bcnt_d  = '0;
          state_d = ST_FILL;
        end
      end
      default: ;
    endcase

    if (start) begin
      key_d   = key;
      iv_d    = iv;
      ov_d    = 1'b0;
      state_d = ST_LOAD;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;

  assign keyed     = ((state_q == ST_FILL) || (state_q == ST_RUN)) && !start;
  assign core_load = (state_q == ST_LOAD);
  assign core_en   = ((state_q == ST_WARM) || (state_q == ST_FILL)) && !start;
  assign core_key  = key_q;
  assign core_iv   = iv_q;

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Directed bench for trivium_stream_ctrl with a stubbed keystream bit source.
module tb_trivium_stream_ctrl;
  import trivium_pkg::*;

  localparam int WARMUP = 1152;
  localparam int RDY_CYC = WARMUP + 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] key;
  logic [79:0] iv;
  logic        keyed, core_load, core_en, core_ks;
  logic [79:0] core_key, core_iv;

  trivium_stream_ctrl_if bus();

  trivium_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .iv        (iv),
    .bus       (bus),
    .keyed     (keyed),
    .core_load (core_load),
    .core_key  (core_key),
    .core_iv   (core_iv),
    .core_en   (core_en),
    .core_ks   (core_ks)
  );

  always #5 clk = ~clk;

  // Core stub: counts enable steps since load; after warm-up it replays
  // ks_pat bit i on the i-th step of each 8-step group, so a full byte
  // packed LSB-first equals ks_pat. During warm-up it toggles to junk.
  logic [7:0] ks_pat;
  int         en_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)            en_cnt <= 0;
    else if (core_load) en_cnt <= 0;
    else if (core_en)   en_cnt <= en_cnt + 1;
  end
  assign core_ks = (en_cnt >= WARMUP) ? ks_pat[(en_cnt - WARMUP) % 8] : en_cnt[0];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue start at the current negedge, then follow the keying sequence
  // until in_ready rises (bounded). Cycle 1 is the cycle after the start edge.
  task automatic run_keying(input logic [79:0] k, input logic [79:0] v,
                            output int first_rdy, output int n_en, output int n_load,
                            output int load_cyc, output int both, output int keyed_cyc,
                            output logic rdy0, output logic ov1, output logic keyed1);
    first_rdy = -1; n_en = 0; n_load = 0; load_cyc = -1; both = 0; keyed_cyc = -1;
    start = 1'b1; key = k; iv = v;
    rdy0 = bus.in_ready;
    @(negedge clk);
    start = 1'b0;
    ov1 = bus.out_valid;
    keyed1 = keyed;
    for (int c = 1; c < RDY_CYC + 50; c++) begin
      if (c > 1) @(negedge clk);
      if (core_load) begin n_load++; if (load_cyc < 0) load_cyc = c; end
      if (core_en) n_en++;
      if (core_load && core_en) both++;
      if (keyed && keyed_cyc < 0) keyed_cyc = c;
      if (bus.in_ready) begin first_rdy = c; break; end
    end
  endtask

  // Offer one byte and wait (bounded) for acceptance; returns at the
  // negedge after the handshake edge with in_valid dropped.
  task automatic send(input logic [7:0] d, input string tag);
    int w;
    bus.in_valid = 1'b1; bus.in_data = d;
    w = 0;
    while (!bus.in_ready && w < 40) begin @(negedge clk); w++; end
    chk({tag, "_accept_timeout"}, 96'(w < 40), 96'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  int fr, ne, nl, lc, bo, kc;
  logic r0, o1, k1;
  int bad;

  initial begin
    rst = 1'b1; start = 1'b0; key = '0; iv = '0; ks_pat = 8'h00;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  96'(bus.in_ready),  96'd0);
    chk("rst_out_valid", 96'(bus.out_valid), 96'd0);
    chk("rst_out_data",  96'(bus.out_data),  96'd0);
    chk("rst_keyed",     96'(keyed),         96'd0);
    chk("rst_core_load", 96'(core_load),     96'd0);
    chk("rst_core_en",   96'(core_en),       96'd0);
    chk("rst_core_key",  96'(core_key),      96'd0);
    rst = 1'b0;
    @(negedge clk);

    // Warm-up count from IDLE.
    ks_pat = 8'hFF;
    run_keying(80'h0123_4567_89AB_CDEF_1357, 80'hFEDC_BA98_7654_3210_2468,
               fr, ne, nl, lc, bo, kc, r0, o1, k1);
    chk("warm_load_count", 96'(nl), 96'd1);
    chk("warm_load_cycle", 96'(lc), 96'd1);
    chk("warm_en_cycles",  96'(ne), 96'(WARMUP + 8));
    chk("warm_load_en",    96'(bo), 96'd0);
    chk("warm_first_rdy",  96'(fr), 96'(RDY_CYC));
    chk("warm_keyed_cyc",  96'(kc), 96'(WARMUP + 2));
    chk("warm_core_key",   96'(core_key), 96'h0123_4567_89AB_CDEF_1357);
    chk("warm_core_iv",    96'(core_iv),  96'hFEDC_BA98_7654_3210_2468);

    // Constant keystream of ones.
    send(8'h5A, "const");
    chk("const_valid", 96'(bus.out_valid), 96'd1);
    chk("const_data",  96'(bus.out_data),  96'hA5);
    chk("const_fill_rdy", 96'(bus.in_ready), 96'd0);
    chk("const_en_in_fill", 96'(core_en), 96'd1);

    // Bit order: first FILL bit lands in bit 0.
    ks_pat = 8'h01;
    run_keying(80'h1, 80'h2, fr, ne, nl, lc, bo, kc, r0, o1, k1);
    chk("bit01_rdy", 96'(fr), 96'(RDY_CYC));
    send(8'h00, "bit01");
    chk("bit01_data", 96'(bus.out_data), 96'h01);
    ks_pat = 8'h80;
    run_keying(80'h3, 80'h4, fr, ne, nl, lc, bo, kc, r0, o1, k1);
    chk("bit80_rdy", 96'(fr), 96'(RDY_CYC));
    send(8'h00, "bit80");
    chk("bit80_data", 96'(bus.out_data), 96'h80);

    // Backpressure: output held, second byte waits, then back-to-back.
    ks_pat = 8'h3C;
    run_keying(80'h5, 80'h6, fr, ne, nl, lc, bo, kc, r0, o1, k1);
    bus.out_ready = 1'b0;
    send(8'h11, "bp1");
    chk("bp_first_data", 96'(bus.out_data), 96'h2D);
    bus.in_valid = 1'b1; bus.in_data = 8'h22;
    bad = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.in_ready || !bus.out_valid || bus.out_data != 8'h2D) bad++;
    end
    chk("bp_hold_violations", 96'(bad), 96'd0);
    chk("bp_core_en_run", 96'(core_en), 96'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_b2b_ready", 96'(bus.in_ready), 96'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_second_valid", 96'(bus.out_valid), 96'd1);
    chk("bp_second_data",  96'(bus.out_data),  96'h1E);

    // Re-key with an output pending and a byte offered in the same cycle.
    bus.out_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("rk_pending_valid", 96'(bus.out_valid), 96'd1);
    ks_pat = 8'hC3;
    bus.in_valid = 1'b1; bus.in_data = 8'h33;
    run_keying(80'hAAAA_5555_AAAA_5555_AAAA, 80'h5555_AAAA_5555_AAAA_5555,
               fr, ne, nl, lc, bo, kc, r0, o1, k1);
    chk("rk_start_rdy",   96'(r0), 96'd0);
    chk("rk_out_cleared", 96'(o1), 96'd0);
    chk("rk_keyed_low",   96'(k1), 96'd0);
    chk("rk_load_cycle",  96'(lc), 96'd1);
    chk("rk_en_cycles",   96'(ne), 96'(WARMUP + 8));
    chk("rk_first_rdy",   96'(fr), 96'(RDY_CYC));
    chk("rk_core_key",    96'(core_key), 96'hAAAA_5555_AAAA_5555_AAAA);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rk_byte_once", 96'(bus.out_data), 96'hF0);
    chk("rk_byte_valid", 96'(bus.out_valid), 96'd1);

    // Asynchronous reset in the middle of warm-up.
    bus.out_ready = 1'b1;
    start = 1'b1; key = 80'h7; iv = 80'h8;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    chk("ar_warm_en", 96'(core_en), 96'd1);
    rst = 1'b1;
    #1;
    chk("ar_state",     96'(dut.state_q == ST_IDLE), 96'd1);
    chk("ar_core_en",   96'(core_en),       96'd0);
    chk("ar_core_load", 96'(core_load),     96'd0);
    chk("ar_in_ready",  96'(bus.in_ready),  96'd0);
    chk("ar_out_valid", 96'(bus.out_valid), 96'd0);
    chk("ar_out_data",  96'(bus.out_data),  96'd0);
    chk("ar_keyed",     96'(keyed),         96'd0);
    chk("ar_core_key",  96'(core_key),      96'd0);
    chk("ar_core_iv",   96'(core_iv),       96'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (core_en || core_load || bus.in_ready || keyed) bad++;
    end
    chk("ar_stays_idle", 96'(bad), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
